// File: rtl/winocnn_pkg.sv
// Shared types and helpers for the Winograd CNN weight path.
// The address helper packs {od, id, k} with a 4-bit element index k.
package winocnn_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, READY, RUN} wtl_state_t;

  localparam int TILE_ELEMS     = 16;
  localparam int TILES_PER_PAIR = 2;
  localparam int K_W            = 4;

  // Tag carried alongside an outstanding SRAM read.
  typedef struct packed {
    logic       valid;
    logic       sel;
    logic [3:0] k;
  } wtl_tag_t;

  function automatic logic [31:0] wtl_pack_addr(input logic [31:0] od,
                                                input logic [31:0] id,
                                                input logic [3:0]  k,
                                                input int          id_w);
    return (od << (id_w + K_W)) | (id << K_W) | 32'(k);
  endfunction

endpackage

// File: rtl/wtl_rd_pipe.sv
// Read-tag pipeline: delays {valid, tile_sel, k} by READ_LAT cycles so each
// SRAM return lands in the tile slot it was issued for.
module wtl_rd_pipe
  import winocnn_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid_i,
  input  logic       issue_sel_i,
  input  logic [3:0] issue_k_i,
  output logic       ret_valid_o,
  output logic       ret_sel_o,
  output logic [3:0] ret_k_o
);

  generate
    for (genvar gi = 0; gi < READ_LAT; gi++) begin : g_stage
      wtl_tag_t stage_q;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage_q <= '0;
          else       stage_q <= '{valid: issue_valid_i, sel: issue_sel_i, k: issue_k_i};
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage_q <= '0;
          else       stage_q <= g_stage[gi-1].stage_q;
        end
      end
    end
  endgenerate

  assign ret_valid_o = g_stage[READ_LAT-1].stage_q.valid;
  assign ret_sel_o   = g_stage[READ_LAT-1].stage_q.sel;
  assign ret_k_o     = g_stage[READ_LAT-1].stage_q.k;

endmodule

// File: rtl/weight_tile_loader.sv
// Weight-side responder of the prepare/start handshake: fetches one or two
// 4x4 transformed weight tiles from SRAM and holds them for the PE array.
module weight_tile_loader
  import winocnn_pkg::*;
#(
  parameter int DW       = 16,
  parameter int OD_W     = 8,
  parameter int ID_W     = 4,
  parameter int READ_LAT = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [OD_W-1:0]                        weight_od1_i,
  input  logic [OD_W-1:0]                        weight_od2_i,
  input  logic [ID_W-1:0]                        weight_id_i,
  input  logic [OD_W-1:0]                        total_od_i,
  input  logic                                   weight_prepare_i,
  input  logic                                   weight_start_i,
  output logic                                   weight_ready_o,
  output logic                                   wsram_ren_o,
  output logic [OD_W+ID_W+K_W-1:0]               wsram_addr_o,
  input  logic [DW-1:0]                          wsram_rdata_i,
  output logic                                   tile_valid_o,
  output logic [TILES_PER_PAIR*TILE_ELEMS*DW-1:0] tile_o
);

  localparam int AW = OD_W + ID_W + K_W;

  wtl_state_t      state_q, state_d;
  logic [OD_W-1:0] od1_q, od2_q;
  logic [ID_W-1:0] id_q;
  logic            pair_q;
  logic [5:0]      issue_q;

  logic            start_load, pair_d, issue, last_ret;
  logic [5:0]      n_reads;
  logic [OD_W-1:0] issue_od;
  logic            ret_valid, ret_sel;
  logic [3:0]      ret_k;

  assign start_load = (state_q == IDLE) && weight_prepare_i;
  assign pair_d     = weight_od2_i < total_od_i;
  assign n_reads    = pair_q ? 6'd32 : 6'd16;
  assign issue      = (state_q == LOAD) && (issue_q < n_reads);
  assign issue_od   = issue_q[4] ? od2_q : od1_q;

  assign wsram_ren_o  = issue;
  assign wsram_addr_o = issue ? AW'(wtl_pack_addr(32'(issue_od), 32'(id_q), issue_q[3:0], ID_W))
                              : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      od1_q   <= '0;
      od2_q   <= '0;
      id_q    <= '0;
      pair_q  <= 1'b0;
      issue_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_load) begin
        od1_q   <= weight_od1_i;
        od2_q   <= weight_od2_i;
        id_q    <= weight_id_i;
        pair_q  <= pair_d;
        issue_q <= '0;
      end else if (issue) begin
        issue_q <= issue_q + 6'd1;
      end
    end
  end

  wtl_rd_pipe #(.READ_LAT(READ_LAT)) u_rd_pipe (
    .clk          (clk),
    .reset        (reset),
    .issue_valid_i(issue),
    .issue_sel_i  (issue_q[4]),
    .issue_k_i    (issue_q[3:0]),
    .ret_valid_o  (ret_valid),
    .ret_sel_o    (ret_sel),
    .ret_k_o      (ret_k)
  );

  // The final return is element 15 of tile2 for a pair, of tile1 otherwise.
  assign last_ret = ret_valid && (ret_sel == pair_q) && (ret_k == 4'd15);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (weight_prepare_i) state_d = LOAD;
      LOAD:    if (last_ret)         state_d = READY;
      READY:   if (weight_start_i)   state_d = RUN;
      RUN:     if (!weight_start_i)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < TILES_PER_PAIR * TILE_ELEMS; gi++) begin : g_elem
      logic [DW-1:0] elem_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          elem_q <= '0;
        end else if (ret_valid && ({ret_sel, ret_k} == 5'(gi))) begin
          elem_q <= wsram_rdata_i;
        end else if ((gi >= TILE_ELEMS) && start_load && !pair_d) begin
          elem_q <= '0;
        end
      end
      assign tile_o[gi*DW +: DW] = elem_q;
    end
  endgenerate

  assign weight_ready_o = (state_q == READY);
  assign tile_valid_o   = (state_q == RUN);

endmodule

// File: tb/tb_weight_tile_loader.sv
// Bench for weight_tile_loader: two instances (read latency 1 and 3) share
// stimulus; each has its own SRAM model backed by one random weight memory.
module tb_weight_tile_loader;

  localparam int DW   = 16;
  localparam int OD_W = 8;
  localparam int ID_W = 4;
  localparam int AW   = OD_W + ID_W + 4;
  localparam int TW   = 32 * DW;

  logic            clk = 1'b0;
  logic            reset;
  logic [OD_W-1:0] od1_s, od2_s, total_s;
  logic [ID_W-1:0] id_s;
  logic            prepare_s, start_s;

  logic            ready1, ren1, valid1, ready3, ren3, valid3;
  logic [AW-1:0]   addr1, addr3;
  logic [DW-1:0]   rdata1, rdata3;
  logic [TW-1:0]   tile1, tile3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  weight_tile_loader #(.DW(DW), .OD_W(OD_W), .ID_W(ID_W), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset), .weight_od1_i(od1_s), .weight_od2_i(od2_s),
    .weight_id_i(id_s), .total_od_i(total_s), .weight_prepare_i(prepare_s),
    .weight_start_i(start_s), .weight_ready_o(ready1), .wsram_ren_o(ren1),
    .wsram_addr_o(addr1), .wsram_rdata_i(rdata1), .tile_valid_o(valid1), .tile_o(tile1)
  );

  weight_tile_loader #(.DW(DW), .OD_W(OD_W), .ID_W(ID_W), .READ_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .weight_od1_i(od1_s), .weight_od2_i(od2_s),
    .weight_id_i(id_s), .total_od_i(total_s), .weight_prepare_i(prepare_s),
    .weight_start_i(start_s), .weight_ready_o(ready3), .wsram_ren_o(ren3),
    .wsram_addr_o(addr3), .wsram_rdata_i(rdata3), .tile_valid_o(valid3), .tile_o(tile3)
  );

  logic [DW-1:0] mem [65536];
  logic [DW-1:0] p3 [3];

  always @(posedge clk) begin
    rdata1 <= mem[addr1];
    p3[0]  <= mem[addr3];
    p3[1]  <= p3[0];
    p3[2]  <= p3[1];
  end
  assign rdata3 = p3[2];

  logic [AW-1:0] q1[$];
  logic [AW-1:0] q3[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (ren1) q1.push_back(addr1);
      if (ren3) q3.push_back(addr3);
    end
  end

  function automatic logic [AW-1:0] a_of(input logic [OD_W-1:0] od, input logic [ID_W-1:0] id,
                                         input int k);
    logic [3:0] kk;
    kk = 4'(k);
    return {od, id, kk};
  endfunction

  // Reference: tile1 from od1, tile2 from od2 only when od2 is a real channel.
  function automatic logic [TW-1:0] exp_tile(input logic [OD_W-1:0] o1, input logic [OD_W-1:0] o2,
                                             input logic [ID_W-1:0] id, input logic [OD_W-1:0] tot);
    logic [TW-1:0] t;
    t = '0;
    for (int k = 0; k < 16; k++) begin
      t[k*DW +: DW] = mem[a_of(o1, id, k)];
      if (o2 < tot) t[(16+k)*DW +: DW] = mem[a_of(o2, id, k)];
    end
    return t;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [OD_W-1:0] o1, input logic [OD_W-1:0] o2,
                                             input logic [ID_W-1:0] id, input int i);
    return a_of((i < 16) ? o1 : o2, id, i % 16);
  endfunction

  task tick;
    @(negedge clk);
  endtask

  task automatic run_load(input logic [OD_W-1:0] o1, input logic [OD_W-1:0] o2,
                          input logic [ID_W-1:0] id, input logic [OD_W-1:0] tot,
                          input bit hold_start, input bit toggle,
                          output int lat1, output int lat3);
    q1.delete();
    q3.delete();
    od1_s = o1; od2_s = o2; id_s = id; total_s = tot;
    prepare_s = 1'b1;
    start_s = hold_start;
    tick;
    prepare_s = 1'b0;
    lat1 = -1;
    lat3 = -1;
    for (int c = 0; c < 200; c++) begin
      if (ready1 && lat1 < 0) lat1 = c;
      if (ready3 && lat3 < 0) lat3 = c;
      if (lat1 >= 0 && lat3 >= 0) break;
      if (toggle) begin
        od1_s = 8'($urandom);
        od2_s = 8'($urandom);
        id_s  = 4'($urandom);
      end
      tick;
    end
  endtask

  task automatic release_pair;
    start_s = 1'b1;
    tick;
    tick;
    start_s = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    od1_s = '0; od2_s = '0; id_s = '0; total_s = '0;
    prepare_s = 1'b0; start_s = 1'b0;
    tick;
    tick;
    total_cnt++;
    if ({ready1, ren1, valid1, addr1} !== '0) $display("FAIL reset_ctrl got %h exp 0", {ready1, ren1, valid1, addr1});
    else pass_cnt++;
    total_cnt++;
    if (tile1 !== '0 || tile3 !== '0) $display("FAIL reset_tile got %h exp 0", tile1);
    else pass_cnt++;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_full_pair;
    int l1, l3;
    run_load(8'd4, 8'd5, 4'd2, 8'd8, 1'b0, 1'b0, l1, l3);
    total_cnt++;
    if (l1 !== 33) $display("FAIL full_lat1 got %0d exp 33", l1); else pass_cnt++;
    total_cnt++;
    if (l3 !== 35) $display("FAIL full_lat3 got %0d exp 35", l3); else pass_cnt++;
    total_cnt++;
    if (q1.size() !== 32) $display("FAIL full_nreads got %0d exp 32", q1.size()); else pass_cnt++;
    for (int i = 0; i < q1.size() && i < 32; i++) begin
      total_cnt++;
      if (q1[i] !== exp_addr(8'd4, 8'd5, 4'd2, i))
        $display("FAIL full_addr[%0d] got %h exp %h", i, q1[i], exp_addr(8'd4, 8'd5, 4'd2, i));
      else pass_cnt++;
    end
    total_cnt++;
    if (tile1 !== exp_tile(8'd4, 8'd5, 4'd2, 8'd8))
      $display("FAIL full_tile1 got %h exp %h", tile1, exp_tile(8'd4, 8'd5, 4'd2, 8'd8));
    else pass_cnt++;
    total_cnt++;
    if (tile3 !== exp_tile(8'd4, 8'd5, 4'd2, 8'd8))
      $display("FAIL full_tile3 got %h exp %h", tile3, exp_tile(8'd4, 8'd5, 4'd2, 8'd8));
    else pass_cnt++;
    $display("full_pair: od 4/5 id 2 lat %0d/%0d reads %0d", l1, l3, q1.size());
    release_pair;
  endtask

  task automatic test_single_tile;
    int l1, l3;
    logic [ID_W-1:0] id;
    id = 4'($urandom);
    run_load(8'd6, 8'd7, id, 8'd7, 1'b0, 1'b0, l1, l3);
    total_cnt++;
    if (l1 !== 17) $display("FAIL single_lat1 got %0d exp 17", l1); else pass_cnt++;
    total_cnt++;
    if (l3 !== 19) $display("FAIL single_lat3 got %0d exp 19", l3); else pass_cnt++;
    total_cnt++;
    if (q1.size() !== 16 || q3.size() !== 16)
      $display("FAIL single_nreads got %0d/%0d exp 16", q1.size(), q3.size());
    else pass_cnt++;
    for (int i = 0; i < q1.size() && i < 16; i++) begin
      total_cnt++;
      if (q1[i] !== exp_addr(8'd6, 8'd7, id, i))
        $display("FAIL single_addr[%0d] got %h exp %h", i, q1[i], exp_addr(8'd6, 8'd7, id, i));
      else pass_cnt++;
    end
    total_cnt++;
    if (tile1[TW-1:TW/2] !== '0) $display("FAIL single_tile2_zero got %h exp 0", tile1[TW-1:TW/2]);
    else pass_cnt++;
    total_cnt++;
    if (tile3 !== exp_tile(8'd6, 8'd7, id, 8'd7))
      $display("FAIL single_tile3 got %h exp %h", tile3, exp_tile(8'd6, 8'd7, id, 8'd7));
    else pass_cnt++;
    $display("single_tile: od 6/7 id %0d lat %0d/%0d reads %0d", id, l1, l3, q1.size());
    release_pair;
  endtask

  task automatic test_run_hold;
    int l1, l3, nvalid;
    logic [OD_W-1:0] o1;
    logic [ID_W-1:0] id;
    logic [TW-1:0]   e;
    o1 = 8'(2 * $urandom_range(0, 6));
    id = 4'($urandom);
    e  = exp_tile(o1, o1 + 8'd1, id, 8'd16);
    run_load(o1, o1 + 8'd1, id, 8'd16, 1'b0, 1'b0, l1, l3);
    nvalid = 0;
    start_s = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (valid1 === 1'b1) nvalid++;
      total_cnt++;
      if (tile1 !== e) $display("FAIL run_tile[%0d] got %h exp %h", c, tile1, e);
      else pass_cnt++;
    end
    start_s = 1'b0;
    tick;
    total_cnt++;
    if (nvalid !== 10) $display("FAIL run_valid_cycles got %0d exp 10", nvalid); else pass_cnt++;
    total_cnt++;
    if (valid1 !== 1'b0 || ready1 !== 1'b0) $display("FAIL run_exit got %b%b exp 00", valid1, ready1);
    else pass_cnt++;
    tick;
    tick;
    total_cnt++;
    if (ready1 !== 1'b0 || tile1 !== e) $display("FAIL idle_retain got %b %h exp 0 %h", ready1, tile1, e);
    else pass_cnt++;
    $display("run_hold: od %0d id %0d valid cycles %0d", o1, id, nvalid);
  endtask

  task automatic test_start_in_load;
    int l1, l3;
    logic [OD_W-1:0] o1;
    logic [ID_W-1:0] id;
    o1 = 8'(2 * $urandom_range(0, 100));
    id = 4'($urandom);
    run_load(o1, o1 + 8'd1, id, 8'd255, 1'b1, 1'b1, l1, l3);
    total_cnt++;
    if (l1 !== 33 || l3 !== 35) $display("FAIL sil_lat got %0d/%0d exp 33/35", l1, l3); else pass_cnt++;
    total_cnt++;
    if (q1.size() !== 32) $display("FAIL sil_nreads got %0d exp 32", q1.size()); else pass_cnt++;
    for (int i = 0; i < q1.size() && i < 32; i++) begin
      total_cnt++;
      if (q1[i] !== exp_addr(o1, o1 + 8'd1, id, i))
        $display("FAIL sil_addr[%0d] got %h exp %h", i, q1[i], exp_addr(o1, o1 + 8'd1, id, i));
      else pass_cnt++;
    end
    total_cnt++;
    if (tile1 !== exp_tile(o1, o1 + 8'd1, id, 8'd255))
      $display("FAIL sil_tile got %h exp %h", tile1, exp_tile(o1, o1 + 8'd1, id, 8'd255));
    else pass_cnt++;
    $display("start_in_load: od %0d id %0d lat %0d/%0d", o1, id, l1, l3);
    tick;
    start_s = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_load;
    int l1, l3;
    logic [ID_W-1:0] id;
    id = 4'($urandom);
    od1_s = 8'd10; od2_s = 8'd11; id_s = id; total_s = 8'd20;
    prepare_s = 1'b1;
    tick;
    prepare_s = 1'b0;
    for (int c = 0; c < 20; c++) tick;
    total_cnt++;
    if (ren1 !== 1'b1 || addr1 !== a_of(8'd11, id, 4))
      $display("FAIL rml_read20 got %b %h exp 1 %h", ren1, addr1, a_of(8'd11, id, 4));
    else pass_cnt++;
    #1 reset = 1'b1;
    #1;
    total_cnt++;
    if ({ready1, ren1, valid1, addr1, ready3, ren3, valid3, addr3} !== '0 || tile1 !== '0 || tile3 !== '0)
      $display("FAIL rml_outputs got %h exp 0", {ready1, ren1, valid1, addr1, ready3, ren3, valid3, addr3});
    else pass_cnt++;
    tick;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) tick;
    total_cnt++;
    if (tile3 !== '0 || ready3 !== 1'b0) $display("FAIL rml_stale got %h exp 0", tile3);
    else pass_cnt++;
    run_load(8'd10, 8'd11, id, 8'd20, 1'b0, 1'b0, l1, l3);
    total_cnt++;
    if (l1 !== 33 || l3 !== 35) $display("FAIL rml_lat got %0d/%0d exp 33/35", l1, l3); else pass_cnt++;
    total_cnt++;
    if (q3.size() !== 32) $display("FAIL rml_nreads got %0d exp 32", q3.size()); else pass_cnt++;
    total_cnt++;
    if (tile3 !== exp_tile(8'd10, 8'd11, id, 8'd20))
      $display("FAIL rml_tile3 got %h exp %h", tile3, exp_tile(8'd10, 8'd11, id, 8'd20));
    else pass_cnt++;
    $display("reset_mid_load: id %0d reload lat %0d/%0d reads %0d", id, l1, l3, q3.size());
    release_pair;
  endtask

  task automatic test_back_to_back;
    int l1, l3;
    logic [OD_W-1:0] o1;
    logic [ID_W-1:0] id;
    logic [TW-1:0]   e;
    for (int p = 0; p < 3; p++) begin
      o1 = 8'(2 * p);
      id = 4'($urandom);
      e  = exp_tile(o1, o1 + 8'd1, id, 8'd8);
      run_load(o1, o1 + 8'd1, id, 8'd8, 1'b0, 1'b0, l1, l3);
      start_s = 1'b1;
      tick;
      total_cnt++;
      if (valid1 !== 1'b1 || tile1 !== e) $display("FAIL b2b_tile1[%0d] got %b %h exp 1 %h", p, valid1, tile1, e);
      else pass_cnt++;
      total_cnt++;
      if (valid3 !== 1'b1 || tile3 !== e) $display("FAIL b2b_tile3[%0d] got %b %h exp 1 %h", p, valid3, tile3, e);
      else pass_cnt++;
      $display("back_to_back: od %0d/%0d id %0d lat %0d/%0d", o1, o1 + 8'd1, id, l1, l3);
      start_s = 1'b0;
      tick;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    test_reset;
    test_full_pair;
    test_single_tile;
    test_run_hold;
    test_start_in_load;
    test_reset_mid_load;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
